adder_sub_arbiter: RTL and testbench
====================================

// Module: adder_sub_arbiter
// PURPOSE
//  Shares one combinational adder_substractor datapath among NREQ requesters.
//  Uses a valid/ready handshake on each request port and on the response port.
//  Round-robin arbitration grants one operation at a time. Operands and the
//  result are registered, giving one response per accepted operation, tagged
//  with the requester id. Sits between the ALU-issue logic and the shared
//  add/sub unit.
// PARAMETERS
//  WIDTH  32  operand/result width in bits (passed to adder_substractor)
//  NREQ   4   number of requesters, >=2; ID_W = $clog2(NREQ)
// PORTS
//  clk        in   1           single clock, all state on rising edge
//  rst_n      in   1           synchronous reset, active-low
//  req_valid  in   NREQ        requester i has an operation pending
//  req_ready  out  NREQ        one-hot grant; handshake when valid[i]&ready[i]
//  req_a      in   NREQ*WIDTH  operand A, requester i at [i*WIDTH +: WIDTH]
//  req_b      in   NREQ*WIDTH  operand B, same packing
//  req_subs   in   NREQ        1 = A-B (two's complement), 0 = A+B
//  rsp_valid  out  1           result available
//  rsp_ready  in   1           consumer accepts result
//  rsp_data   out  WIDTH       S of the operation, modulo 2^WIDTH
//  rsp_id     out  ID_W        index of the requester that issued the operation
//  rsp_zero   out  1           rsp_data == 0
// BEHAVIOUR
//  Reset (rst_n=0 at edge):
//   state=IDLE, rr_ptr=0, rsp_valid=0, rsp_data=0, rsp_id=0, rsp_zero=0,
//   operand regs=0. req_ready=0 while rst_n=0.
//  FSM states: IDLE -> EXEC -> RESP -> IDLE.
//   IDLE:
//    - Winner = first i with req_valid[i], searching rr_ptr, rr_ptr+1, ...
//      and wrapping at NREQ.
//    - req_ready[winner]=1 combinationally; all other bits 0.
//    - On handshake: latch a/b/subs/id of the winner, set rr_ptr =
//      (winner+1) mod NREQ, go to EXEC.
//    - No valid: remain in IDLE; rr_ptr unchanged.
//   EXEC:
//    - Latched operands drive adder_substractor.
//    - Latch S into rsp_data, compute rsp_zero, set rsp_valid=1, go to RESP.
//   RESP:
//    - Hold rsp_* stable until rsp_ready=1.
//    - On rsp_valid&rsp_ready: rsp_valid=0, go to IDLE.
//  req_ready is 0 in EXEC and RESP.
//  Timing and throughput:
//   - Handshake at edge T -> rsp_valid=1 after edge T+1 (visible cycle T+1).
//   - Minimum spacing between grants is 3 cycles.
//  Arithmetic: wrap-around, no overflow/carry flag; e.g. 0-1 = all ones.
//  Requester may change or drop inputs after its handshake; the latched copy
//  is used.
//  req_valid may drop before grant; that request is simply not granted.
//  Reset mid-operation, in any state: the in-flight operation is discarded,
//  no response is produced, and rr_ptr returns to 0.
//  X on req_* of non-granted requesters must not propagate to outputs.
// STRUCTURE
//  Package adder_sub_pkg:
//   - typedef enum logic[1:0] {IDLE, EXEC, RESP} arb_state_t
//   - localparam ID_W helper
//  Sub-module rr_arbiter:
//   - Inputs: req vector, rr_ptr, enable. Output: one-hot grant + index.
//   - Combinational and reusable.
//  Datapath: existing adder_substractor #(WIDTH) instantiated once, fed from
//  the operand registers.
// TESTING
//  1 Reset: hold rst_n=0 3 cycles with all req_valid=1 -> req_ready=0,
//    rsp_valid=0, rsp_data=0.
//  2 Add: req0 A=5, B=3, subs=0 -> rsp_data=8, rsp_id=0, rsp_zero=0,
//    rsp_valid one cycle after the handshake.
//  3 Sub/wrap:
//    - A=3, B=3, subs=1 -> 0, zero=1.
//    - A=0, B=1, subs=1 -> 32'hFFFFFFFF.
//    - A=32'hFFFFFFFF, B=1, subs=0 -> 0, zero=1.
//  4 Fairness: all 4 req_valid held high, rsp_ready=1 -> grant order
//    0, 1, 2, 3, 0, 1 with matching rsp_id; no requester starved.
//  5 Backpressure: rsp_ready=0 for 5 cycles in RESP -> rsp_valid, data and id
//    stable; req_ready all 0 until rsp_ready=1.
//  6 Reset mid-EXEC: rst_n=0 one cycle during EXEC -> no rsp_valid for that op;
//    after release, req2 alone is granted from rr_ptr=0 and its result is
//    correct.

Source files
------------

// File: rtl/adder_sub_pkg.sv
// Shared types and helpers for the arbitrated add/sub unit.
package adder_sub_pkg;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} arb_state_t;

  // Width of a requester index; a single-requester build still needs one bit.
  function automatic int idWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/adder_substractor.sv
// Combinational wrap-around adder/subtractor: s = subs ? a - b : a + b.
module adder_substractor #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             subs,
  output logic [WIDTH-1:0] s
);

  // Two's-complement subtract: invert B and feed subs in as the carry.
  assign s = a + (b ^ {WIDTH{subs}}) + {{(WIDTH-1){1'b0}}, subs};

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first active request at or after ptr wins.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int ID_W = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [ID_W-1:0] ptr,
  input  logic            enable,
  output logic [NREQ-1:0] grant,
  output logic [ID_W-1:0] grantIdx,
  output logic            grantAny
);

  always_comb begin
    int k;
    grant    = '0;
    grantIdx = '0;
    grantAny = 1'b0;
    k        = 0;
    for (int off = 0; off < NREQ; off++) begin
      k = (int'(ptr) + off) % NREQ;
      if (enable && !grantAny && req[k]) begin
        grantAny    = 1'b1;
        grant[k]    = 1'b1;
        grantIdx    = ID_W'(k);
      end
    end
  end

endmodule

// File: rtl/adder_sub_arbiter.sv
// Shares one adder_substractor among NREQ requesters with round-robin grants,
// registered operands and a registered, id-tagged response.
//
// state | meaning
// IDLE  | grant the round-robin winner, latch its operands on handshake
// EXEC  | latched operands through the adder, capture result
// RESP  | hold response until the consumer accepts it
module adder_sub_arbiter
  import adder_sub_pkg::*;
#(
  parameter  int WIDTH = 32,
  parameter  int NREQ  = 4,
  localparam int ID_W  = idWidth(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  input  logic [NREQ-1:0]       req_subs,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [WIDTH-1:0]      rsp_data,
  output logic [ID_W-1:0]       rsp_id,
  output logic                  rsp_zero
);

  arb_state_t       state, nextState;
  logic [ID_W-1:0]  rrPtr, nextPtr, winIdx, opId;
  logic [NREQ-1:0]  grant;
  logic             grantAny, arbEnable, handshake;
  logic [WIDTH-1:0] opA, opB, selA, selB, sum;
  logic             opSubs, selSubs;

  assign arbEnable = rst_n && (state == IDLE);

  rr_arbiter #(.NREQ(NREQ), .ID_W(ID_W)) uArb (
    .req      (req_valid),
    .ptr      (rrPtr),
    .enable   (arbEnable),
    .grant    (grant),
    .grantIdx (winIdx),
    .grantAny (grantAny)
  );

  assign req_ready = grant;
  assign handshake = grantAny;
  assign nextPtr   = (winIdx == ID_W'(NREQ - 1)) ? '0 : winIdx + 1'b1;

  // Only the winner's slice is ever selected, so idle requesters cannot leak X.
  always_comb begin
    selA    = '0;
    selB    = '0;
    selSubs = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (winIdx == ID_W'(i)) begin
        selA    = req_a[i*WIDTH +: WIDTH];
        selB    = req_b[i*WIDTH +: WIDTH];
        selSubs = req_subs[i];
      end
    end
  end

  adder_substractor #(.WIDTH(WIDTH)) uAddSub (
    .a    (opA),
    .b    (opB),
    .subs (opSubs),
    .s    (sum)
  );

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (handshake) nextState = EXEC;
      EXEC:    nextState = RESP;
      RESP:    if (rsp_ready) nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      rrPtr     <= '0;
      opA       <= '0;
      opB       <= '0;
      opSubs    <= 1'b0;
      opId      <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_id    <= '0;
      rsp_zero  <= 1'b0;
    end else begin
      state <= nextState;
      case (state)
        IDLE: if (handshake) begin
          opA    <= selA;
          opB    <= selB;
          opSubs <= selSubs;
          opId   <= winIdx;
          rrPtr  <= nextPtr;
        end
        EXEC: begin
          rsp_data  <= sum;
          rsp_zero  <= (sum == '0);
          rsp_id    <= opId;
          rsp_valid <= 1'b1;
        end
        RESP: if (rsp_ready) rsp_valid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_adder_sub_arbiter.sv
// Randomized and directed bench for adder_sub_arbiter against a queue-free
// round-robin reference model.
module tb_adder_sub_arbiter;
  localparam int WIDTH = 32;
  localparam int NREQ  = 4;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [NREQ-1:0]       req_valid, req_ready, req_subs;
  logic [NREQ*WIDTH-1:0] req_a, req_b;
  logic                  rsp_valid, rsp_ready, rsp_zero;
  logic [WIDTH-1:0]      rsp_data;
  logic [1:0]            rsp_id;

  int total = 0;
  int bad   = 0;
  int modelPtr = 0;
  logic [WIDTH-1:0] va[NREQ];
  logic [WIDTH-1:0] vb[NREQ];
  logic             vs[NREQ];

  adder_sub_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_subs  (req_subs),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id),
    .rsp_zero  (rsp_zero)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  task automatic checkEq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Active requesters get their operands, idle ones are driven with X.
  task automatic drive(input logic [NREQ-1:0] mask);
    for (int i = 0; i < NREQ; i++) begin
      req_a[i*WIDTH +: WIDTH] = mask[i] ? va[i] : 'x;
      req_b[i*WIDTH +: WIDTH] = mask[i] ? vb[i] : 'x;
      req_subs[i]             = mask[i] ? vs[i] : 1'bx;
    end
    req_valid = mask;
  endtask

  task automatic scramble();
    for (int i = 0; i < NREQ; i++) begin
      req_a[i*WIDTH +: WIDTH] = $urandom;
      req_b[i*WIDTH +: WIDTH] = $urandom;
      req_subs[i]             = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic randOperands();
    for (int i = 0; i < NREQ; i++) begin
      va[i] = $urandom;
      vb[i] = $urandom;
      vs[i] = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) vb[i] = va[i];
    end
  endtask

  function automatic int pickWinner(input logic [NREQ-1:0] mask);
    for (int off = 0; off < NREQ; off++)
      if (mask[(modelPtr + off) % NREQ]) return (modelPtr + off) % NREQ;
    return -1;
  endfunction

  function automatic logic [WIDTH-1:0] refResult(input int w);
    longint unsigned r;
    if (vs[w]) r = longint'(va[w]) - longint'(vb[w]);
    else       r = longint'(va[w]) + longint'(vb[w]);
    return WIDTH'(r % (64'd1 << WIDTH));
  endfunction

  // Called at a negedge with the DUT idle; returns at a negedge, DUT idle.
  task automatic doOp(input logic [NREQ-1:0] mask, input bit keep, input int stall);
    int w;
    logic [WIDTH-1:0] expD;
    drive(mask);
    rsp_ready = 1'b0;
    #1;
    w = pickWinner(mask);
    if (w < 0) begin
      checkEq("idle_ready", req_ready, 0);
      @(negedge clk);
      checkEq("idle_rsp", rsp_valid, 0);
      return;
    end
    checkEq("grant", req_ready, 64'(1) << w);
    expD = refResult(w);
    modelPtr = (w + 1) % NREQ;
    @(posedge clk);
    #1;
    if (!keep) req_valid = '0;
    scramble();
    @(negedge clk);
    checkEq("exec_valid", rsp_valid, 0);
    checkEq("exec_ready", req_ready, 0);
    @(negedge clk);
    checkEq("rsp_valid", rsp_valid, 1);
    checkEq("rsp_data", rsp_data, expD);
    checkEq("rsp_id", rsp_id, w);
    checkEq("rsp_zero", rsp_zero, expD == 0);
    checkEq("resp_ready", req_ready, 0);
    for (int c = 0; c < stall; c++) begin
      @(negedge clk);
      checkEq("hold_valid", rsp_valid, 1);
      checkEq("hold_data", rsp_data, expD);
      checkEq("hold_id", rsp_id, w);
      checkEq("hold_ready", req_ready, 0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    checkEq("rsp_done", rsp_valid, 0);
    rsp_ready = 1'b0;
  endtask

  task automatic pulseReset();
    rst_n = 1'b0;
    req_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;
    modelPtr = 0;
  endtask

  // Grant an operation, then reset while it is in EXEC; no response may appear.
  task automatic resetMidExec(input logic [NREQ-1:0] mask);
    int w;
    drive(mask);
    #1;
    w = pickWinner(mask);
    checkEq("rme_grant", req_ready, 64'(1) << w);
    @(posedge clk);
    #1;
    req_valid = '0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checkEq("rme_valid", rsp_valid, 0);
    checkEq("rme_ready", req_ready, 0);
    rst_n = 1'b1;
    modelPtr = 0;
    @(negedge clk);
    checkEq("rme_after", rsp_valid, 0);
    @(negedge clk);
    checkEq("rme_after2", rsp_valid, 0);
  endtask

  initial begin
    rst_n     = 1'b0;
    rsp_ready = 1'b0;
    randOperands();
    drive('1);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checkEq("rst_ready", req_ready, 0);
      checkEq("rst_valid", rsp_valid, 0);
      checkEq("rst_data", rsp_data, 0);
    end
    rst_n = 1'b1;
    req_valid = '0;
    @(negedge clk);

    va[0] = 32'd5;          vb[0] = 32'd3; vs[0] = 1'b0; doOp(4'b0001, 0, 0);
    va[0] = 32'd3;          vb[0] = 32'd3; vs[0] = 1'b1; doOp(4'b0001, 0, 0);
    va[0] = 32'd0;          vb[0] = 32'd1; vs[0] = 1'b1; doOp(4'b0001, 0, 0);
    va[0] = 32'hFFFF_FFFF;  vb[0] = 32'd1; vs[0] = 1'b0; doOp(4'b0001, 0, 0);

    pulseReset();
    for (int n = 0; n < 6; n++) begin
      randOperands();
      doOp(4'hF, 1, 0);
    end

    randOperands();
    doOp(4'hF, 1, 5);

    randOperands();
    resetMidExec(4'b0010);
    randOperands();
    doOp(4'b0100, 0, 0);
    randOperands();
    resetMidExec(4'b0110);
    randOperands();
    doOp(4'b1010, 0, 0);

    for (int n = 0; n < 60; n++) begin
      randOperands();
      doOp(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), $urandom_range(0, 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
